opensync_protocol_encapsulate: RTL and testbench

//  Transmit-side counterpart of the OpenSync decapsulator in the opensync_1gmac path.
//  - Wraps selected frames in a 32-byte OpenSync header that carries a 64-bit time value.
//  - Forwards all other frames unchanged.
//  - Sits between the time-sync frame source and the 1G MAC TX byte interface.
//  - Uses a fixed 33-cycle delay line, so header insertion needs no back-pressure.

---
 rtl/opensync_protocol_encapsulate.sv | 156 +++++++++++++++
 tb/tb_opensync_protocol_encapsulate.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/opensync_protocol_encapsulate.sv
// rtl/opensync_protocol_encapsulate.sv - OpenSync header encapsulator for the 1G MAC TX byte path
//
// Wraps selected frames in a 32-byte OpenSync header that carries a 64-bit time value.
// All other frames are forwarded unchanged.
//
// Every input byte runs through a 32-stage shift line plus a registered tap, so it
// leaves 33 cycles after it arrived. The header is sent in the 32 cycles before the
// first delayed data byte, which means no back-pressure is needed.
//
// Optional build macro: OPENSYNC_ENCAP_CNT_EN adds ov_encap_cnt / ov_err_cnt.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   iv_data, i_data_wr input frame bytes; a frame is a contiguous run of i_data_wr=1
//   i_encap_req        sampled at start of frame: 1 = encapsulate this frame
//   iv_time            sampled at start of frame: time placed in header bytes 24..31
//   ov_data, o_data_wr output byte stream
//   o_encap_err        1-cycle pulse: encapsulation refused, frame sent plain
//   ov_encap_cnt       (optional) count of encapsulated frames
//   ov_err_cnt         (optional) count of refused requests
module opensync_protocol_encapsulate #(
    parameter logic [47:0] DMAC     = 48'h0180_C200_000E,
    parameter logic [47:0] SMAC     = 48'h0000_0000_0001,
    parameter logic [7:0]  MSG_TYPE = 8'h06,
    parameter logic [7:0]  SUB_TYPE = 8'h03
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  iv_data,
    input  logic        i_data_wr,
    input  logic        i_encap_req,
    input  logic [63:0] iv_time,
    output logic [7:0]  ov_data,
    output logic        o_data_wr,
    output logic        o_encap_err
`ifdef OPENSYNC_ENCAP_CNT_EN
    ,
    output logic [15:0] ov_encap_cnt,
    output logic [15:0] ov_err_cnt
`endif
);

    localparam int DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE_S   = 2'd0,
        HEADER_S = 2'd1,
        TRAN_S   = 2'd2
    } state_t;

    state_t       state_q;
    logic [7:0]   dl_data_q [DEPTH];
    logic [DEPTH-1:0] dl_vld_q;
    logic         tap_vld_q;
    logic         wr_prev_q;
    logic [4:0]   cnt_q;
    logic [63:0]  time_q;
    logic [7:0]   data_q;
    logic         data_wr_q;
    logic         err_q;

    logic         sof;
    logic         line_busy;
    logic         accept;
    logic         refuse;
    logic [255:0] hdr_vec;
    logic [7:0]   hdr_base;

    assign sof       = i_data_wr & ~wr_prev_q;
    // The registered tap counts as the last delay stage: a frame is still in flight
    // until its final byte has left the tap.
    assign line_busy = (|dl_vld_q) | tap_vld_q;
    assign accept    = sof & i_encap_req & (state_q == IDLE_S) & ~line_busy;
    assign refuse    = sof & i_encap_req & ~accept;

    assign hdr_vec  = {DMAC, SMAC, 16'hFF01, MSG_TYPE, SUB_TYPE, 64'h0, time_q};
    assign hdr_base = 8'd255 - {cnt_q, 3'b000};

    assign ov_data     = data_q;
    assign o_data_wr   = data_wr_q;
    assign o_encap_err = err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE_S;
            for (int i = 0; i < DEPTH; i++) dl_data_q[i] <= 8'h00;
            dl_vld_q  <= '0;
            tap_vld_q <= 1'b0;
            wr_prev_q <= 1'b0;
            cnt_q     <= 5'd0;
            time_q    <= 64'h0;
            data_q    <= 8'h00;
            data_wr_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_prev_q    <= i_data_wr;
            // Idle slots carry zero data so the output is 0 whenever o_data_wr=0.
            dl_data_q[0] <= i_data_wr ? iv_data : 8'h00;
            for (int i = 1; i < DEPTH; i++) dl_data_q[i] <= dl_data_q[i-1];
            dl_vld_q     <= {dl_vld_q[DEPTH-2:0], i_data_wr};
            tap_vld_q    <= dl_vld_q[DEPTH-1];
            err_q        <= refuse;

            case (state_q)
                IDLE_S: begin
                    if (accept) begin
                        // Header byte 0 goes out now; cnt_q indexes the next byte.
                        state_q   <= HEADER_S;
                        time_q    <= iv_time;
                        cnt_q     <= 5'd1;
                        data_q    <= DMAC[47:40];
                        data_wr_q <= 1'b1;
                    end else begin
                        data_q    <= dl_data_q[DEPTH-1];
                        data_wr_q <= dl_vld_q[DEPTH-1];
                    end
                end
                HEADER_S: begin
                    data_q    <= hdr_vec[hdr_base -: 8];
                    data_wr_q <= 1'b1;
                    cnt_q     <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= TRAN_S;
                end
                TRAN_S: begin
                    data_q    <= dl_data_q[DEPTH-1];
                    data_wr_q <= dl_vld_q[DEPTH-1];
                    if (!dl_vld_q[DEPTH-1]) state_q <= IDLE_S;
                end
                default: begin
                    state_q   <= IDLE_S;
                    data_q    <= 8'h00;
                    data_wr_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef OPENSYNC_ENCAP_CNT_EN
    logic [15:0] encap_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            encap_cnt_q <= 16'h0;
            err_cnt_q   <= 16'h0;
        end else begin
            if (accept) encap_cnt_q <= encap_cnt_q + 16'h1;
            if (refuse) err_cnt_q   <= err_cnt_q + 16'h1;
        end
    end

    assign ov_encap_cnt = encap_cnt_q;
    assign ov_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_opensync_protocol_encapsulate.sv
// tb/tb_opensync_protocol_encapsulate.sv - self-checking bench for opensync_protocol_encapsulate
module tb_opensync_protocol_encapsulate;

    localparam int SZ  = 8192;
    localparam int LAT = 33;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  iv_data = 8'h00;
    logic        i_data_wr = 1'b0;
    logic        i_encap_req = 1'b0;
    logic [63:0] iv_time = 64'h0;
    logic [7:0]  ov_data;
    logic        o_data_wr;
    logic        o_encap_err;
`ifdef OPENSYNC_ENCAP_CNT_EN
    logic [15:0] ov_encap_cnt;
    logic [15:0] ov_err_cnt;
`endif

    always #5 i_clk = ~i_clk;

    opensync_protocol_encapsulate dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .iv_data     (iv_data),
        .i_data_wr   (i_data_wr),
        .i_encap_req (i_encap_req),
        .iv_time     (iv_time),
        .ov_data     (ov_data),
        .o_data_wr   (o_data_wr),
        .o_encap_err (o_encap_err)
`ifdef OPENSYNC_ENCAP_CNT_EN
        ,
        .ov_encap_cnt(ov_encap_cnt),
        .ov_err_cnt  (ov_err_cnt)
`endif
    );

    // Reference model: expected output per absolute cycle number.
    logic       exp_wr  [SZ];
    logic [7:0] exp_d   [SZ];
    logic       exp_err [SZ];
    logic       hist_wr [SZ];
    int cyc = 0;
    int floor_cyc = 0;
    int n_encap = 0;
    int n_err = 0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick();
        if (cyc >= SZ - LAT - 2) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, SZ - LAT - 2);
            $fatal(1, "cycle budget exhausted");
        end
        @(negedge i_clk);
        chk("data_wr", 64'(o_data_wr), 64'(exp_wr[cyc]));
        chk("data", 64'(ov_data), 64'(exp_d[cyc]));
        chk("encap_err", 64'(o_encap_err), 64'(exp_err[cyc]));
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic header_bytes(input logic [63:0] tm, output logic [7:0] hb [32]);
        logic [47:0] dmac;
        logic [47:0] smac;
        dmac = 48'h0180_C200_000E;
        smac = 48'h0000_0000_0001;
        for (int i = 0; i < 6; i++) hb[i] = 8'(dmac >> (8 * (5 - i)));
        for (int i = 0; i < 6; i++) hb[6 + i] = 8'(smac >> (8 * (5 - i)));
        hb[12] = 8'hFF;
        hb[13] = 8'h01;
        hb[14] = 8'h06;
        hb[15] = 8'h03;
        for (int i = 16; i < 24; i++) hb[i] = 8'h00;
        for (int i = 0; i < 8; i++) hb[24 + i] = 8'(tm >> (8 * (7 - i)));
    endtask

    task automatic drive(input logic wr, input logic [7:0] d, input logic req, input logic [63:0] tm);
        logic prev;
        logic busy;
        logic [7:0] hb [32];
        i_data_wr   = wr;
        iv_data     = d;
        i_encap_req = req;
        iv_time     = tm;
        hist_wr[cyc] = wr;
        prev = (cyc > 0) ? hist_wr[cyc-1] : 1'b0;
        if (wr) begin
            exp_wr[cyc + LAT] = 1'b1;
            exp_d[cyc + LAT]  = d;
        end
        if (wr && !prev && req) begin
            // Refused if any byte entered in the previous 33 cycles (since reset).
            busy = 1'b0;
            for (int k = 1; k <= LAT; k++)
                if (cyc - k >= floor_cyc && hist_wr[cyc-k]) busy = 1'b1;
            if (busy) begin
                exp_err[cyc + 1] = 1'b1;
                n_err++;
            end else begin
                header_bytes(tm, hb);
                for (int j = 0; j < 32; j++) begin
                    exp_wr[cyc + 1 + j] = 1'b1;
                    exp_d[cyc + 1 + j]  = hb[j];
                end
                n_encap++;
            end
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 8'($urandom), 1'($urandom), {$urandom, $urandom});
    endtask

    task automatic send_frame(input int gap, input int n, input logic req, input logic [63:0] tm);
        idle(gap);
        drive(1'b1, 8'($urandom), req, tm);
        // Non-SOF cycles carry random req/time that must be ignored.
        for (int k = 1; k < n; k++)
            drive(1'b1, 8'($urandom), 1'($urandom), {$urandom, $urandom});
    endtask

    task automatic reset_cycles(input int n);
        i_rst_n = 1'b0;
        for (int i = cyc; i < SZ; i++) begin
            exp_wr[i]  = 1'b0;
            exp_d[i]   = 8'h00;
            exp_err[i] = 1'b0;
        end
        n_encap = 0;
        n_err   = 0;
        for (int i = 0; i < n; i++) begin
            i_data_wr   = 1'b0;
            iv_data     = 8'h00;
            i_encap_req = 1'b0;
            hist_wr[cyc] = 1'b0;
            tick();
        end
        i_rst_n   = 1'b1;
        floor_cyc = cyc;
    endtask

    initial begin
        for (int i = 0; i < SZ; i++) hist_wr[i] = 1'b0;
        @(posedge i_clk);
        #1;
        reset_cycles(3);
        idle(4);

        // Encapsulated 60-byte frame with the reference time value.
        send_frame(1, 60, 1'b1, 64'h0102_0304_0506_0708);
        // Plain 64-byte frame.
        send_frame(40, 64, 1'b0, 64'hDEAD_BEEF_0000_0001);
        // Second request 10 cycles after the first: refused.
        send_frame(40, 20, 1'b1, 64'h1111_2222_3333_4444);
        send_frame(10, 20, 1'b1, 64'h5555_6666_7777_8888);
        // 40-cycle gaps: both encapsulated.
        send_frame(40, 20, 1'b1, 64'h0A0B_0C0D_0E0F_1011);
        send_frame(40, 20, 1'b1, 64'hA0B0_C0D0_E0F0_0102);
        // Boundary gaps: 32 idle cycles is refused, 33 is accepted.
        send_frame(32, 5, 1'b1, 64'hCAFE_0000_0000_0032);
        send_frame(33, 5, 1'b1, 64'hCAFE_0000_0000_0033);
        // Short frame of 1 byte.
        send_frame(40, 1, 1'b1, 64'h0000_0000_0000_0001);

`ifdef OPENSYNC_ENCAP_CNT_EN
        idle(1);
        chk("encap_cnt", 64'(ov_encap_cnt), 64'(n_encap));
        chk("err_cnt", 64'(ov_err_cnt), 64'(n_err));
`endif

        // Reset while header byte 10 is on the output, then a clean frame.
        send_frame(40, 11, 1'b1, 64'h7777_7777_7777_7777);
        reset_cycles(2);
        send_frame(3, 60, 1'b1, 64'h0102_0304_0506_0708);

        // Randomized traffic.
        for (int f = 0; f < 25; f++)
            send_frame($urandom_range(1, 45), $urandom_range(1, 80),
                       1'($urandom_range(0, 3) != 0), {$urandom, $urandom});
        idle(80);

`ifdef OPENSYNC_ENCAP_CNT_EN
        chk("encap_cnt_end", 64'(ov_encap_cnt), 64'(n_encap));
        chk("err_cnt_end", 64'(ov_err_cnt), 64'(n_err));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
